// File: rtl/uart_frame_parser_if.sv
// uart_frame_parser_if: byte-in strobe, payload ready/valid stream and frame
// status signals of the UART frame parser, bundled for port connection.
// The slave modport is the parser side; the master modport is the side that
// feeds bytes in and consumes the payload stream.
interface uart_frame_parser_if;
    logic       axiiv;
    logic [7:0] axiid;
    logic       axiov;
    logic [7:0] axiod;
    logic       axiol;
    logic       axiir;
    logic       frame_ok;
    logic       frame_err;
    logic       busy;

    modport slave (
        input  axiiv, axiid, axiir,
        output axiov, axiod, axiol, frame_ok, frame_err, busy
    );

    modport master (
        output axiiv, axiid, axiir,
        input  axiov, axiod, axiol, frame_ok, frame_err, busy
    );
endinterface

// File: rtl/uart_frame_parser.sv
// uart_frame_parser: recognises A5 / N / payload[N] / XOR-checksum frames from
// single-cycle byte strobes, buffers the payload and replays it on a
// ready/valid stream only after the checksum has verified.
// Optional feature: define PARSER_TIMEOUT_EN to abort a frame whose bytes stop
// arriving for TIMEOUT_CYCLES clocks while in LEN, PAYLOAD or CSUM.
module uart_frame_parser #(
    parameter int MAX_LEN        = 64,
    parameter int TIMEOUT_CYCLES = 208340
) (
    input  logic               clk,
    input  logic               rst,
    uart_frame_parser_if.slave bus
);

    localparam int         AW        = $clog2(MAX_LEN);
    localparam logic [8:0] MAX_LEN_W = 9'(MAX_LEN);

    // Reject parameter sets the buffer addressing cannot represent.
    generate
        if (MAX_LEN < 2 || MAX_LEN > 256 || (MAX_LEN & (MAX_LEN - 1)) != 0 ||
            TIMEOUT_CYCLES < 1) begin : g_bad_params
            $error("uart_frame_parser: MAX_LEN must be a power of two in 2..256, TIMEOUT_CYCLES >= 1");
        end
    endgenerate

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN,
        S_PAYLOAD,
        S_CSUM,
        S_DRAIN
    } state_t;

    state_t          state_q, state_d;
    logic [7:0]      len_q, len_d;
    logic [7:0]      acc_q, acc_d;
    logic [AW-1:0]   wr_idx_q, wr_idx_d;   // buffer write address, wraps at MAX_LEN
    logic [8:0]      wr_cnt_q, wr_cnt_d;   // full count of payload bytes written
    logic [8:0]      rd_idx_q, rd_idx_d;   // next buffer index to fetch in DRAIN
    logic            axiov_q, axiov_d;
    logic            axiol_q, axiol_d;
    logic            frame_ok_q, frame_ok_d;
    logic            frame_err_q, frame_err_d;
    logic            busy_q, busy_d;
    logic [7:0]      axiod_q;
    logic            wr_en;
    logic            rd_en;

    logic [7:0]      mem [MAX_LEN];

`ifdef PARSER_TIMEOUT_EN
    localparam int            TW      = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);
    logic [TW-1:0]            idle_cnt_q, idle_cnt_d;
`endif

    // Next-state and next-output computation for the frame FSM.
    always_comb begin
        state_d     = state_q;
        len_d       = len_q;
        acc_d       = acc_q;
        wr_idx_d    = wr_idx_q;
        wr_cnt_d    = wr_cnt_q;
        rd_idx_d    = rd_idx_q;
        axiov_d     = axiov_q;
        axiol_d     = axiol_q;
        frame_ok_d  = 1'b0;
        frame_err_d = 1'b0;
        wr_en       = 1'b0;
        rd_en       = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (bus.axiiv && bus.axiid == 8'hA5) begin
                    state_d = S_LEN;
                end
            end
            S_LEN: begin
                if (bus.axiiv) begin
                    len_d    = bus.axiid;
                    acc_d    = bus.axiid;
                    wr_idx_d = '0;
                    wr_cnt_d = '0;
                    if ({1'b0, bus.axiid} > MAX_LEN_W) begin
                        frame_err_d = 1'b1;
                        state_d     = S_IDLE;
                    end else if (bus.axiid == 8'h00) begin
                        state_d = S_CSUM;
                    end else begin
                        state_d = S_PAYLOAD;
                    end
                end
            end
            S_PAYLOAD: begin
                if (bus.axiiv) begin
                    wr_en    = 1'b1;
                    wr_idx_d = wr_idx_q + 1'b1;
                    wr_cnt_d = wr_cnt_q + 9'd1;
                    acc_d    = acc_q ^ bus.axiid;
                    if (wr_cnt_q + 9'd1 == {1'b0, len_q}) begin
                        state_d = S_CSUM;
                    end
                end
            end
            S_CSUM: begin
                if (bus.axiiv) begin
                    if (bus.axiid != acc_q) begin
                        frame_err_d = 1'b1;
                        state_d     = S_IDLE;
                    end else begin
                        frame_ok_d = 1'b1;
                        rd_idx_d   = '0;
                        state_d    = (len_q != 8'h00) ? S_DRAIN : S_IDLE;
                    end
                end
            end
            S_DRAIN: begin
                // The output register may be refilled when empty or when its
                // current byte is being accepted this cycle.
                if (!axiov_q || bus.axiir) begin
                    if (rd_idx_q < {1'b0, len_q}) begin
                        rd_en    = 1'b1;
                        rd_idx_d = rd_idx_q + 9'd1;
                        axiov_d  = 1'b1;
                        axiol_d  = (rd_idx_q == ({1'b0, len_q} - 9'd1));
                    end else begin
                        axiov_d = 1'b0;
                        axiol_d = 1'b0;
                        state_d = S_IDLE;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

`ifdef PARSER_TIMEOUT_EN
        idle_cnt_d = '0;
        if (state_q == S_LEN || state_q == S_PAYLOAD || state_q == S_CSUM) begin
            if (bus.axiiv) begin
                idle_cnt_d = '0;
            end else if (idle_cnt_q == TO_LAST) begin
                frame_err_d = 1'b1;
                state_d     = S_IDLE;
                idle_cnt_d  = '0;
            end else begin
                idle_cnt_d = idle_cnt_q + 1'b1;
            end
        end
`endif

        busy_d = (state_d != S_IDLE);
    end

    // Frame FSM state and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            len_q       <= '0;
            acc_q       <= '0;
            wr_idx_q    <= '0;
            wr_cnt_q    <= '0;
            rd_idx_q    <= '0;
            axiov_q     <= 1'b0;
            axiol_q     <= 1'b0;
            frame_ok_q  <= 1'b0;
            frame_err_q <= 1'b0;
            busy_q      <= 1'b0;
`ifdef PARSER_TIMEOUT_EN
            idle_cnt_q  <= '0;
`endif
        end else begin
            state_q     <= state_d;
            len_q       <= len_d;
            acc_q       <= acc_d;
            wr_idx_q    <= wr_idx_d;
            wr_cnt_q    <= wr_cnt_d;
            rd_idx_q    <= rd_idx_d;
            axiov_q     <= axiov_d;
            axiol_q     <= axiol_d;
            frame_ok_q  <= frame_ok_d;
            frame_err_q <= frame_err_d;
            busy_q      <= busy_d;
`ifdef PARSER_TIMEOUT_EN
            idle_cnt_q  <= idle_cnt_d;
`endif
        end
    end

    // Payload buffer write port.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_idx_q] <= bus.axiid;
        end
    end

    // Registered buffer read; only advances on a fetch so the byte holds under stall.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            axiod_q <= '0;
        end else if (rd_en) begin
            axiod_q <= mem[rd_idx_q[AW-1:0]];
        end
    end

    assign bus.axiov     = axiov_q;
    assign bus.axiod     = axiod_q;
    assign bus.axiol     = axiol_q;
    assign bus.frame_ok  = frame_ok_q;
    assign bus.frame_err = frame_err_q;
    assign bus.busy      = busy_q;

endmodule

// File: tb/tb_uart_frame_parser.sv
// tb_uart_frame_parser: directed bench for uart_frame_parser. Expected payload
// bytes are queued when a frame is sent; a monitor pops and compares them as
// the parser hands them over, and also checks hold-under-stall.
module tb_uart_frame_parser;

    localparam int TB_MAX_LEN = 64;
    localparam int TB_TIMEOUT = 40;

    logic clk = 1'b0;
    logic rst = 1'b1;

    uart_frame_parser_if bus ();

    uart_frame_parser #(
        .MAX_LEN        (TB_MAX_LEN),
        .TIMEOUT_CYCLES (TB_TIMEOUT)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int         n_total  = 0;
    int         n_pass   = 0;
    int         ok_cnt   = 0;
    int         err_cnt  = 0;
    int         xfer_cnt = 0;
    int         exp_ok   = 0;
    int         exp_err  = 0;
    logic [8:0] sb [$];
    bit         prev_stall = 1'b0;
    logic [7:0] prev_d;
    logic       prev_l;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    endtask

    task automatic send(input logic [7:0] b, input int gap);
        bus.axiiv = 1'b1;
        bus.axiid = b;
        @(negedge clk);
        bus.axiiv = 1'b0;
        repeat (gap) @(negedge clk);
    endtask

    task automatic wait_idle(input bit rnd);
        bit done = 1'b0;
        for (int k = 0; k < 400 && !done; k++) begin
            if (rnd) bus.axiir = 1'($urandom_range(0, 1));
            @(negedge clk);
            if (!bus.busy && !bus.axiov) done = 1'b1;
        end
        bus.axiir = 1'b1;
        check("drain_done", 32'(done), 32'd1);
    endtask

    // Output monitor: sampled just before the rising edge so inputs have settled.
    always @(negedge clk) begin
        logic [8:0] e;
        #2;
        if (rst) begin
            prev_stall = 1'b0;
        end else begin
            if (bus.frame_ok)  ok_cnt++;
            if (bus.frame_err) err_cnt++;
            if (prev_stall) begin
                check("hold_valid", 32'(bus.axiov), 32'd1);
                check("hold_byte", 32'({bus.axiol, bus.axiod}), 32'({prev_l, prev_d}));
            end
            if (bus.axiov && bus.axiir) begin
                xfer_cnt++;
                check("out_expected", 32'(sb.size() != 0), 32'd1);
                if (sb.size() != 0) begin
                    e = sb.pop_front();
                    check("out_byte", 32'({bus.axiol, bus.axiod}), 32'(e));
                end
            end
            prev_stall = bus.axiov && !bus.axiir;
            prev_d     = bus.axiod;
            prev_l     = bus.axiol;
        end
    end

    initial begin
        int         xbase;
        logic [7:0] pl [TB_MAX_LEN];
        logic [7:0] cs;

        bus.axiiv = 1'b0;
        bus.axiid = 8'h00;
        bus.axiir = 1'b1;
        repeat (3) @(negedge clk);

        // Reset values
        check("rst_axiov", 32'(bus.axiov), 32'd0);
        check("rst_axiod", 32'(bus.axiod), 32'd0);
        check("rst_axiol", 32'(bus.axiol), 32'd0);
        check("rst_ok", 32'(bus.frame_ok), 32'd0);
        check("rst_err", 32'(bus.frame_err), 32'd0);
        check("rst_busy", 32'(bus.busy), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Good 3-byte frame, downstream always ready
        sb.push_back({1'b0, 8'h11});
        sb.push_back({1'b0, 8'h22});
        sb.push_back({1'b1, 8'h33});
        send(8'hA5, 1); send(8'h03, 1); send(8'h11, 1); send(8'h22, 1); send(8'h33, 1);
        send(8'h03, 0);
        exp_ok++;
        check("t1_frame_ok", 32'(bus.frame_ok), 32'd1);
        check("t1_busy_drain", 32'(bus.busy), 32'd1);
        @(negedge clk);
        check("t1_b0", 32'({bus.axiov, bus.axiol, bus.axiod}), 32'({1'b1, 1'b0, 8'h11}));
        @(negedge clk);
        check("t1_b1", 32'({bus.axiov, bus.axiol, bus.axiod}), 32'({1'b1, 1'b0, 8'h22}));
        @(negedge clk);
        check("t1_b2", 32'({bus.axiov, bus.axiol, bus.axiod}), 32'({1'b1, 1'b1, 8'h33}));
        @(negedge clk);
        check("t1_end_valid", 32'(bus.axiov), 32'd0);
        check("t1_end_busy", 32'(bus.busy), 32'd0);
        repeat (2) @(negedge clk);
        check("t1_ok_cnt", 32'(ok_cnt), 32'(exp_ok));
        check("t1_sb_empty", 32'(sb.size()), 32'd0);

        // Same frame with a bad checksum
        send(8'hA5, 1); send(8'h03, 1); send(8'h11, 1); send(8'h22, 1); send(8'h33, 1);
        send(8'h04, 0);
        exp_err++;
        check("t2_frame_err", 32'(bus.frame_err), 32'd1);
        check("t2_busy", 32'(bus.busy), 32'd0);
        repeat (4) @(negedge clk);
        check("t2_err_cnt", 32'(err_cnt), 32'(exp_err));
        check("t2_ok_cnt", 32'(ok_cnt), 32'(exp_ok));

        // Garbage then an empty frame
        send(8'h00, 1); send(8'h7F, 1); send(8'hA5, 1); send(8'h00, 1);
        send(8'h00, 0);
        exp_ok++;
        check("t3_frame_ok", 32'(bus.frame_ok), 32'd1);
        check("t3_busy", 32'(bus.busy), 32'd0);
        repeat (4) @(negedge clk);
        check("t3_ok_cnt", 32'(ok_cnt), 32'(exp_ok));
        check("t3_no_out", 32'(xfer_cnt), 32'd3);

        // Oversized length, then bytes that must be ignored
        send(8'hA5, 1);
        send(8'h41, 0);
        exp_err++;
        check("t4_frame_err", 32'(bus.frame_err), 32'd1);
        check("t4_busy", 32'(bus.busy), 32'd0);
        send(8'h11, 1); send(8'h00, 1); send(8'h00, 1); send(8'h03, 1);
        check("t4_ignored_busy", 32'(bus.busy), 32'd0);
        repeat (2) @(negedge clk);
        check("t4_err_cnt", 32'(err_cnt), 32'(exp_err));
        check("t4_ok_cnt", 32'(ok_cnt), 32'(exp_ok));

        // Toggling ready, header injected during drain
        sb.push_back({1'b0, 8'hAA});
        sb.push_back({1'b1, 8'hBB});
        send(8'hA5, 1); send(8'h02, 1); send(8'hAA, 1); send(8'hBB, 1);
        send(8'h13, 0);
        exp_ok++;
        check("t5_frame_ok", 32'(bus.frame_ok), 32'd1);
        xbase = xfer_cnt;
        for (int i = 0; i < 10; i++) begin
            if (i == 2) check("t5_hold_aa", 32'({bus.axiov, bus.axiol, bus.axiod}), 32'({1'b1, 1'b0, 8'hAA}));
            if (i == 3) check("t5_bb_last", 32'({bus.axiov, bus.axiol, bus.axiod}), 32'({1'b1, 1'b1, 8'hBB}));
            bus.axiir = (i % 2 == 0);
            bus.axiiv = (i == 3);
            bus.axiid = 8'hA5;
            @(negedge clk);
        end
        bus.axiiv = 1'b0;
        bus.axiir = 1'b1;
        check("t5_xfers", 32'(xfer_cnt - xbase), 32'd2);
        check("t5_busy", 32'(bus.busy), 32'd0);
        check("t5_sb_empty", 32'(sb.size()), 32'd0);
        send(8'h00, 1); send(8'h00, 1);
        repeat (2) @(negedge clk);
        check("t5_a5_discarded", 32'(ok_cnt), 32'(exp_ok));

        // Reset mid-payload
        send(8'hA5, 1); send(8'h05, 1); send(8'h01, 1); send(8'h02, 1);
        #1 rst = 1'b1;
        #1;
        check("t6_pl_outs", 32'({bus.axiov, bus.axiol, bus.frame_ok, bus.frame_err, bus.busy}), 32'd0);
        check("t6_pl_axiod", 32'(bus.axiod), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check("t6_pl_no_err", 32'(err_cnt), 32'(exp_err));

        // Reset mid-drain with the output stalled
        bus.axiir = 1'b0;
        sb.push_back({1'b1, 8'h55});
        send(8'hA5, 1); send(8'h01, 1); send(8'h55, 1);
        send(8'h54, 0);
        exp_ok++;
        @(negedge clk);
        check("t6_dr_valid", 32'({bus.axiov, bus.axiol, bus.axiod}), 32'({1'b1, 1'b1, 8'h55}));
        #1 rst = 1'b1;
        #1;
        check("t6_dr_outs", 32'({bus.axiov, bus.axiol, bus.frame_err, bus.busy}), 32'd0);
        check("t6_dr_axiod", 32'(bus.axiod), 32'd0);
        sb.delete();
        @(negedge clk);
        rst = 1'b0;
        bus.axiir = 1'b1;
        repeat (3) @(negedge clk);
        check("t6_dr_ok_cnt", 32'(ok_cnt), 32'(exp_ok));
        check("t6_dr_err_cnt", 32'(err_cnt), 32'(exp_err));

        // Full MAX_LEN frame with random ready
        cs = 8'(TB_MAX_LEN);
        for (int i = 0; i < TB_MAX_LEN; i++) begin
            pl[i] = 8'(i * 7 + 3);
            cs    = cs ^ pl[i];
            sb.push_back({(i == TB_MAX_LEN - 1), pl[i]});
        end
        send(8'hA5, 1);
        send(8'(TB_MAX_LEN), 1);
        for (int i = 0; i < TB_MAX_LEN; i++) send(pl[i], i % 2);
        send(cs, 0);
        exp_ok++;
        check("t7_frame_ok", 32'(bus.frame_ok), 32'd1);
        wait_idle(1'b1);
        repeat (2) @(negedge clk);
        check("t7_sb_empty", 32'(sb.size()), 32'd0);
        check("t7_ok_cnt", 32'(ok_cnt), 32'(exp_ok));

`ifdef PARSER_TIMEOUT_EN
        // Stalled frame aborts after the idle limit
        begin
            int cyc  = 0;
            bit seen = 1'b0;
            send(8'hA5, 1);
            send(8'h05, 0);
            for (int k = 1; k <= 4 * TB_TIMEOUT && !seen; k++) begin
                @(negedge clk);
                if (bus.frame_err) begin
                    seen = 1'b1;
                    cyc  = k;
                end
            end
            exp_err++;
            check("t8_to_seen", 32'(seen), 32'd1);
            check("t8_to_cycles", 32'(cyc), 32'(TB_TIMEOUT));
            repeat (2) @(negedge clk);
            check("t8_err_cnt", 32'(err_cnt), 32'(exp_err));
        end
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
